// File: rtl/mem_responder_if.sv
// Memory-side bus between the cache and the memory responder.
// Master drives requests; slave returns registered responses and status.
interface mem_responder_if #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 32
) ();

  logic [1:0]            req_op;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_data;
  logic                  rsp_vld;
  logic [DATA_WIDTH-1:0] rsp_data;
  logic                  busy;
  logic                  err_drop;
  logic [7:0]            drop_cnt;

  modport master (
    output req_op, req_addr, req_data,
    input  rsp_vld, rsp_data, busy, err_drop, drop_cnt
  );

  modport slave (
    input  req_op, req_addr, req_data,
    output rsp_vld, rsp_data, busy, err_drop, drop_cnt
  );

endinterface

// File: rtl/mem_responder.sv
// Word-addressed memory responder: immediate writes, fixed-latency reads.
// Optional MEM_RESPONDER_DROP_CHECK_EN adds drop flag/counter and report.
module mem_responder #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 32,
  parameter int LATENCY    = 4
) (
  input logic            clk,
  input logic            rst,
  mem_responder_if.slave bus
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [1:0] OP_RD = 2'd1;
  localparam logic [1:0] OP_WR = 2'd2;
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  typedef enum logic {
    IDLE,
    BUSY
  } state_t;

  state_t                state_q;
  state_t                state_d;
  logic [3:0]            cnt_q;
  logic [3:0]            cnt_d;
  logic                  acc_rd;
  logic                  acc_wr;
  logic                  done;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] cap_q;
  logic                  vld_q;
  logic [DATA_WIDTH-1:0] rsp_q;

  // Next-state: accept in IDLE, count down latency in BUSY.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_rd  = 1'b0;
    acc_wr  = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      IDLE: begin
        unique case (1'b1)
          (bus.req_op == OP_RD): begin
            acc_rd  = 1'b1;
            state_d = BUSY;
            cnt_d   = CNT_INIT;
          end
          (bus.req_op == OP_WR): acc_wr = 1'b1;
          default: ;
        endcase
      end
      BUSY: begin
        if (cnt_q == 4'd0) begin
          done    = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and latency counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Storage array; reset clears every word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (acc_wr) begin
      mem[bus.req_addr] <= bus.req_data;
    end
  end

  // Capture read data at acceptance, present it on completion.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cap_q <= '0;
      vld_q <= 1'b0;
      rsp_q <= '0;
    end else begin
      vld_q <= done;
      if (acc_rd) cap_q <= mem[bus.req_addr];
      if (done) rsp_q <= cap_q;
    end
  end

  assign bus.rsp_vld  = vld_q;
  assign bus.rsp_data = rsp_q;
  assign bus.busy     = (state_q == BUSY);

`ifdef MEM_RESPONDER_DROP_CHECK_EN
  logic       drop;
  logic       err_q;
  logic [7:0] dcnt_q;

  assign drop = (state_q == BUSY) &&
                (bus.req_op == OP_RD || bus.req_op == OP_WR);

  // Sticky drop flag and saturating drop counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q  <= 1'b0;
      dcnt_q <= 8'd0;
    end else if (drop) begin
      err_q <= 1'b1;
      if (dcnt_q != 8'hff) dcnt_q <= dcnt_q + 8'd1;
    end
  end

  // Report each dropped request in simulation.
  always @(posedge clk) begin
    if (!rst && drop)
      $error("mem_responder drop op=%0d addr=%0h t=%0t",
             bus.req_op, bus.req_addr, $time);
  end

  assign bus.err_drop = err_q;
  assign bus.drop_cnt = dcnt_q;
`else
  assign bus.err_drop = 1'b0;
  assign bus.drop_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_mem_responder.sv
// Directed plus random stimulus for mem_responder.
// Reference model tracks pending read by due-edge number.
module tb_mem_responder;

  localparam int AW  = 6;
  localparam int DW  = 32;
  localparam int LAT = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;

  mem_responder_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  mem_responder #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .LATENCY(LAT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [DW-1:0] mm [1<<AW];
  bit            pend;
  int            due;
  logic [DW-1:0] pdata;
  int            e;
  int            drops;
  logic          x_vld;
  logic [DW-1:0] x_rsp;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    logic [7:0] xd;
    logic       xe;
`ifdef MEM_RESPONDER_DROP_CHECK_EN
    xd = (drops > 255) ? 8'd255 : 8'(drops);
    xe = (drops != 0);
`else
    xd = 8'd0;
    xe = 1'b0;
`endif
    chk({tag, ".vld"},  64'(bus.rsp_vld),  64'(x_vld));
    chk({tag, ".data"}, 64'(bus.rsp_data), 64'(x_rsp));
    chk({tag, ".busy"}, 64'(bus.busy),     64'(pend));
    chk({tag, ".err"},  64'(bus.err_drop), 64'(xe));
    chk({tag, ".dcnt"}, 64'(bus.drop_cnt), 64'(xd));
  endtask

  task automatic model_reset();
    for (int i = 0; i < (1 << AW); i++) mm[i] = '0;
    pend  = 1'b0;
    drops = 0;
    x_vld = 1'b0;
    x_rsp = '0;
  endtask

  task automatic step(input string tag, input logic [1:0] op,
                      input logic [AW-1:0] a, input logic [DW-1:0] d);
    @(negedge clk);
    bus.req_op   = op;
    bus.req_addr = a;
    bus.req_data = d;
    @(posedge clk);
    e++;
    x_vld = 1'b0;
    if (pend) begin
      if (op == 2'd1 || op == 2'd2) drops++;
      if (e == due) begin
        x_vld = 1'b1;
        x_rsp = pdata;
        pend  = 1'b0;
      end
    end else if (op == 2'd2) begin
      mm[a] = d;
    end else if (op == 2'd1) begin
      pend  = 1'b1;
      due   = e + LAT;
      pdata = mm[a];
    end
    #1;
    chk_all(tag);
  endtask

  task automatic nops(input string tag, input int n);
    for (int i = 0; i < n; i++) step(tag, 2'd0, '0, '0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    bus.req_op = 2'd0;
    rst = 1'b1;
    model_reset();
    #1;
    chk_all("rst_async");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    bus.req_op   = 2'd0;
    bus.req_addr = '0;
    bus.req_data = '0;
    e = 0;
    model_reset();

    do_reset();
    step("rd5", 2'd1, 6'd5, '0);
    nops("rd5_wait", LAT);
    chk("rd5_pulse", 64'(bus.rsp_vld), 64'd1);

    step("wr3", 2'd2, 6'd3, 32'hDEADBEEF);
    step("rd3", 2'd1, 6'd3, '0);
    nops("rd3_wait", LAT);
    chk("rd3_data", 64'(bus.rsp_data), 64'hDEADBEEF);
    nops("rd3_after", 1);

    step("wr7", 2'd2, 6'd7, 32'h11);
    step("rd7", 2'd1, 6'd7, '0);
    step("wr7_drop", 2'd2, 6'd7, 32'h22);
    nops("rd7_wait", LAT - 1);
    chk("rd7_data", 64'(bus.rsp_data), 64'h11);
    step("rd7_again", 2'd1, 6'd7, '0);
    nops("rd7b_wait", LAT);
    chk("rd7b_data", 64'(bus.rsp_data), 64'h11);

    step("b2b_a", 2'd1, 6'd3, '0);
    nops("b2b_wait", LAT - 1);
    step("b2b_drop", 2'd1, 6'd7, '0);
    step("b2b_acc", 2'd1, 6'd7, '0);
    nops("b2b_tail", LAT);

    for (int i = 0; i < 200; i++)
      step("rand", 2'($urandom_range(0, 3)), 6'($urandom_range(0, 15)),
           $urandom);

    step("mid_rd", 2'd1, 6'd3, '0);
    nops("mid_wait", 2);
    do_reset();
    nops("mid_quiet", 8);
    step("mid_rd3", 2'd1, 6'd3, '0);
    nops("mid_rd3_w", LAT);
    chk("mid_zero3", 64'(bus.rsp_data), 64'd0);
    step("mid_rd7", 2'd1, 6'd7, '0);
    nops("mid_rd7_w", LAT);

    do_reset();
    while (drops < 300)
      step("sat", 2'($urandom_range(1, 2)), 6'($urandom_range(0, 63)),
           $urandom);
    nops("sat_tail", LAT + 1);
`ifdef MEM_RESPONDER_DROP_CHECK_EN
    chk("sat_cnt", 64'(bus.drop_cnt), 64'd255);
`else
    chk("sat_cnt", 64'(bus.drop_cnt), 64'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
# mem_responder

Behavioural main-memory responder for the cache test environment. It sits on the memory side of the cache's memory bus and is driven by the cache's request outputs `req_op`, `req_addr` and `req_data`. It holds a word-addressed array, commits writes immediately and returns read data after a fixed, configurable latency. It also raises `rsp_vld` and reports protocol violations where the initiator issues a request while a read is outstanding.

## Interface
- `ADDR_WIDTH`, default 6: word-address width; array depth is 2^ADDR_WIDTH.
- `DATA_WIDTH`, default 32: data word width.
- `LATENCY`, default 4: clock edges from read acceptance to `rsp_vld`; legal range 1..15.

Ports:
- `clk`  input  1  bus clock; all state changes on the rising edge.
- `rst`  input  1  asynchronous, active-high reset, driven by the bus initiator.
- `req_op`  input  2  operation. Encodings:
  - 0 = NOP
  - 1 = READ
  - 2 = WRITE
  - 3 = reserved, treated as NOP
- `req_addr`  input  ADDR_WIDTH  word address.
- `req_data`  input  DATA_WIDTH  write data.
- `rsp_vld`  output  1  one-cycle pulse; read data valid.
- `rsp_data`  output  DATA_WIDTH  read data; holds its last value between responses.
- `busy`  output  1  high while a read is outstanding.
- `err_drop`  output  1  sticky flag: a non-NOP request was dropped.
- `drop_cnt`  output  8  count of dropped requests.

## Operation
- **States:** IDLE and BUSY. A 4-bit down-counter `cnt` tracks read latency.
- **Reset (asynchronous, while rst=1):**
  - State is IDLE, `cnt`=0.
  - `rsp_vld`=0, `rsp_data`=0, `busy`=0, `err_drop`=0, `drop_cnt`=0.
  - All array words are cleared to 0.
- **IDLE, WRITE:** `mem[req_addr]` ← `req_data` at the edge. State stays IDLE. No response is generated.
- **IDLE, READ:**
  - `mem[req_addr]` is captured into the response register at the accepting edge.
  - State moves to BUSY and `cnt` ← LATENCY−1.
  - Later writes do not alter the captured data.
- **IDLE, NOP or reserved:** no effect.
- **BUSY:**
  - While `cnt`≠0, `cnt` decrements each edge.
  - At the edge where `cnt`=0: `rsp_vld`←1, `rsp_data`← captured data, state ← IDLE.
  - At the following edge `rsp_vld`←0 unless a new response completes at that same edge.
- **Request while BUSY (READ or WRITE):**
  - The request is dropped: no array update and no response.
  - `err_drop`←1.
  - `drop_cnt` increments and saturates at 255.
  - This includes a request presented at the same edge that completes the read, because the state is still BUSY when that request is sampled.
- **Addressing:** `req_addr` indexes the full array, so no out-of-range address exists.
- **Reset mid-read:** the outstanding read is discarded. No `rsp_vld` is produced after reset deasserts.

## Timing
- Read accepted at edge k gives `rsp_vld`=1 for exactly the cycle between edges k+LATENCY and k+LATENCY+1.
- With LATENCY=1, `rsp_vld` is high in the cycle immediately after acceptance.
- `busy` is registered: high from edge k to edge k+LATENCY, low from edge k+LATENCY onward.
- Earliest next accepted request is at edge k+LATENCY+1, so read-to-read throughput is one per LATENCY+1 cycles.
- Writes complete at the accepting edge. A READ at the next edge to the same address returns the new data.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Configuration
- **Macro:** `MEM_RESPONDER_DROP_CHECK_EN`.
- **Defined:**
  - Drop detection is compiled in; `err_drop` and `drop_cnt` behave as above.
  - At each drop, a simulation `$error` is issued reporting op, address and time.
- **Undefined:**
  - Drop logic is removed; `err_drop` and `drop_cnt` are tied to 0.
  - Requests while BUSY are still silently ignored.

## Test plan
- **Reset values:** assert rst mid-cycle for 2 cycles, then READ address 5 → `rsp_vld` pulse at edge k+4 with `rsp_data`=0, and all status outputs are 0.
- **Write then read:**
  - Stimulus: WRITE address 3 data 0xDEADBEEF, then READ address 3 at the next edge.
  - Required response: with LATENCY=4, `rsp_vld` is high for exactly one cycle, 4 edges after read acceptance, with `rsp_data`=0xDEADBEEF; `busy` is high 4 cycles.
- **Read data capture:** READ address 7 (holding 0x11), then WRITE address 7 data 0x22 during BUSY → response 0x11, write dropped, `err_drop`=1, `drop_cnt`=1; a later READ of address 7 returns 0x11.
- **Back-to-back reads:** issue a READ at the completion edge and at the edge after it → first is dropped (`drop_cnt`+1), second is accepted.
- **Reset mid-read:** READ accepted, rst pulsed 2 edges later → no `rsp_vld` ever appears; `busy`=0 and the array is zeroed.
- **Saturation and macro:** 300 dropped requests → `drop_cnt`=255. With `MEM_RESPONDER_DROP_CHECK_EN` undefined, the same stimulus gives `drop_cnt`=0 and `err_drop`=0.
